if_stage: RTL and testbench

Instruction-fetch stage of the non-forwarding pipelined RV32I core. Owns the program counter, drives the word address into the combinational instruction memory, and registers the returned instruction with its PC into the IF/ID pipeline register. Accepts stall requests from the hazard unit and redirects from branch/jump resolution in EX, and squashes wrong-path fetches into NOPs.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/if_stage_if.sv | 18 +
 rtl/if_id_reg.sv | 32 +++
 rtl/if_stage.sv | 85 ++++++++
 tb/tb_if_stage.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: NOP encoding, default reset PC,
// and the IF/ID pipeline bundle.
package riscv_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_four;
    logic [31:0] inst;
    logic        valid;
    logic        misalign;
  } if_id_t;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus.
// master: fetch address out, instruction word in (combinational memory).
interface if_stage_if;

  logic [31:0] o_addr_inst;
  logic [31:0] i_inst;

  modport master (
    output o_addr_inst,
    input  i_inst
  );

  modport slave (
    input  o_addr_inst,
    output i_inst
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Priority: reset > flush > stall > load; flush/reset insert NOP_INST.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter logic [31:0] NOP_INST = riscv_pkg::NOP_INST
) (
  input  logic   i_clk,
  input  logic   i_reset,
  input  logic   i_flush,
  input  logic   i_stall,
  input  if_id_t i_d,
  output if_id_t o_q
);

  if_id_t r_q;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_q.pc       <= 32'h0;
      r_q.pc_four  <= 32'h4;
      r_q.inst     <= NOP_INST;
      r_q.valid    <= 1'b0;
      r_q.misalign <= 1'b0;
    end else if (!i_stall) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC select, IF/ID register.
// Ports: clk/reset, stall/flush/redirect controls, imem bus, IF/ID outputs.
module if_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INST = riscv_pkg::NOP_INST
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_redirect_en,
  input  logic [31:0] i_redirect_pc,
  if_stage_if.master  imem,
  output logic [31:0] o_id_pc,
  output logic [31:0] o_id_pc_four,
  output logic [31:0] o_id_inst,
  output logic        o_id_valid,
  output logic        o_id_misalign
);

  logic [31:0] r_pc;
  logic        r_mis_pend;
  logic [31:0] w_pc_four;
  logic        w_flush;
  if_id_t      w_d;
  if_id_t      w_q;

  assign w_pc_four = r_pc + 32'd4;

  // Redirect makes the word being fetched wrong-path.
  assign w_flush = i_flush | i_redirect_en;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc <= RESET_PC;
    end else if (i_redirect_en) begin
      r_pc <= {i_redirect_pc[31:2], 2'b00};
    end else if (!i_stall) begin
      r_pc <= w_pc_four;
    end
  end

  // Misalign flag rides with the first fetch from a redirected PC.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mis_pend <= 1'b0;
    end else if (i_redirect_en) begin
      r_mis_pend <= |i_redirect_pc[1:0];
    end else if (i_flush) begin
      r_mis_pend <= 1'b0;
    end else if (!i_stall) begin
      r_mis_pend <= 1'b0;
    end
  end

  always_comb begin
    w_d          = '0;
    w_d.pc       = r_pc;
    w_d.pc_four  = w_pc_four;
    w_d.inst     = imem.i_inst;
    w_d.valid    = 1'b1;
    w_d.misalign = r_mis_pend;
  end

  if_id_reg #(
    .NOP_INST(NOP_INST)
  ) u_if_id (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_flush(w_flush),
    .i_stall(i_stall),
    .i_d    (w_d),
    .o_q    (w_q)
  );

  assign imem.o_addr_inst = r_pc;
  assign o_id_pc          = w_q.pc;
  assign o_id_pc_four     = w_q.pc_four;
  assign o_id_inst        = w_q.inst;
  assign o_id_valid       = w_q.valid;
  assign o_id_misalign    = w_q.misalign;

endmodule

// File: tb/tb_if_stage.sv
// Randomised self-checking bench for if_stage against a
// fetch-level reference model plus directed literal checks.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        redir;
  logic [31:0] rpc;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        id_mis;

  int tests = 0;
  int fails = 0;

  if_stage_if imem ();

  // Memory image: word at address A is A ^ 0xA0.
  assign imem.i_inst = imem.o_addr_inst ^ 32'h0000_00A0;

  if_stage dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_stall      (stall),
    .i_flush      (flush),
    .i_redirect_en(redir),
    .i_redirect_pc(rpc),
    .imem         (imem),
    .o_id_pc      (id_pc),
    .o_id_pc_four (id_pc4),
    .o_id_inst    (id_inst),
    .o_id_valid   (id_valid),
    .o_id_misalign(id_mis)
  );

  always #5 clk = ~clk;

  // Reference model: fetch PC, pending misalign, and the ID slot.
  logic [31:0] m_pc;
  logic        m_pend;
  logic [31:0] m_ipc;
  logic [31:0] m_ipc4;
  logic [31:0] m_inst;
  logic        m_valid;
  logic        m_mis;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc    = 32'h0;
    m_pend  = 1'b0;
    m_ipc   = 32'h0;
    m_ipc4  = 32'h4;
    m_inst  = 32'h13;
    m_valid = 1'b0;
    m_mis   = 1'b0;
  endtask

  // Apply one cycle of controls, advance model, clock, compare.
  task automatic step(input logic r, input logic s, input logic f,
                      input logic rd, input logic [31:0] t);
    logic [31:0] pc_now;
    logic        squash;
    rst   = r;
    stall = s;
    flush = f;
    redir = rd;
    rpc   = t;
    pc_now = m_pc;
    squash = f || rd;
    if (r) begin
      model_reset();
    end else begin
      if (squash) begin
        m_ipc   = 32'h0;
        m_ipc4  = 32'h4;
        m_inst  = 32'h13;
        m_valid = 1'b0;
        m_mis   = 1'b0;
      end else if (!s) begin
        m_ipc   = pc_now;
        m_ipc4  = pc_now + 32'd4;
        m_inst  = pc_now ^ 32'hA0;
        m_valid = 1'b1;
        m_mis   = m_pend;
      end
      if (rd) begin
        m_pc   = t & 32'hFFFF_FFFC;
        m_pend = (t % 4) != 0;
      end else begin
        if (f || !s) m_pend = 1'b0;
        if (!s) m_pc = pc_now + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    chk("addr",     imem.o_addr_inst, m_pc);
    chk("id_pc",    id_pc,   m_ipc);
    chk("id_pc4",   id_pc4,  m_ipc4);
    chk("id_inst",  id_inst, m_inst);
    chk("id_valid", {31'b0, id_valid}, {31'b0, m_valid});
    chk("id_mis",   {31'b0, id_mis},   {31'b0, m_mis});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; stall = 0; flush = 0; redir = 0; rpc = 0;
    model_reset();
    #1;
    // Reset state, pinned with literals.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("rst_addr",  imem.o_addr_inst, 32'h0);
    chk("rst_inst",  id_inst, 32'h0000_0013);
    chk("rst_valid", {31'b0, id_valid}, 32'h0);
    chk("rst_pc4",   id_pc4, 32'h4);

    // Sequential fetch.
    run(1);
    chk("seq0_addr", imem.o_addr_inst, 32'h4);
    chk("seq0_inst", id_inst, 32'hA0);
    chk("seq0_v",    {31'b0, id_valid}, 32'h1);
    run(1);
    chk("seq1_pc",   id_pc, 32'h4);
    chk("seq1_inst", id_inst, 32'hA4);

    // Stall at PC=8.
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("stall_addr", imem.o_addr_inst, 32'h8);
    chk("stall_idpc", id_pc, 32'h4);
    run(1);
    chk("resume_pc",  id_pc, 32'h8);
    chk("resume_ins", id_inst, 32'hA8);

    // Redirect under stall.
    step(0, 1, 0, 1, 32'h100);
    chk("rd_addr",  imem.o_addr_inst, 32'h100);
    chk("rd_valid", {31'b0, id_valid}, 32'h0);
    run(1);
    chk("rd_idpc",  id_pc, 32'h100);
    chk("rd_v",     {31'b0, id_valid}, 32'h1);

    // Misaligned redirect.
    step(0, 0, 0, 1, 32'h102);
    chk("mis_addr", imem.o_addr_inst, 32'h100);
    run(1);
    chk("mis_set",  {31'b0, id_mis}, 32'h1);
    run(1);
    chk("mis_clr",  {31'b0, id_mis}, 32'h0);

    // Misaligned redirect, stalled before the target loads.
    step(0, 0, 0, 1, 32'h203);
    step(0, 1, 0, 0, 0);
    run(1);
    chk("mis_stl",  {31'b0, id_mis}, 32'h1);

    // Flush alone at PC=0x20.
    step(0, 0, 0, 1, 32'h20);
    step(0, 0, 1, 0, 0);
    chk("fl_addr",  imem.o_addr_inst, 32'h24);
    chk("fl_inst",  id_inst, 32'h13);

    // PC wrap.
    step(0, 0, 0, 1, 32'hFFFF_FFFC);
    run(1);
    chk("wrap",     imem.o_addr_inst, 32'h0);
    chk("wrap_pc4", id_pc4, 32'h0);

    // Reset during stall.
    run(3);
    step(1, 1, 0, 1, 32'h400);
    chk("rs_addr",  imem.o_addr_inst, 32'h0);
    chk("rs_pc",    id_pc, 32'h0);
    chk("rs_inst",  id_inst, 32'h13);
    run(1);
    chk("rs_first", id_inst, 32'hA0);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      logic r, s, f, d;
      r = ($urandom_range(0, 49) == 0);
      s = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 7) == 0);
      d = ($urandom_range(0, 6) == 0);
      step(r, s, f, d, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
